// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter.
// State encoding and grant identifiers.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_D  = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker, purely combinational.
// Ports: req[1:0] in, last in, grant out, valid out.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |req;
        grant = GNT_IF;
        unique case (1'b1)
            (req == 2'b11): grant = ~last;
            (req == 2'b10): grant = GNT_D;
            default:        grant = GNT_IF;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared memory between the IF and D ports.
// Ports: clk, reset(active-low sync), IF/D req-ack ports, mem_* side.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_BYTES   = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic              if_err,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic              d_err,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writeData,
    output logic              mem_memRead,
    output logic              mem_memWrite,
    input  logic [DATA_W-1:0] mem_memData
);

    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(MEM_BYTES - 4);
    localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES);

    arb_state_t state, state_n;

    logic              last_grant;
    logic              gnt;
    logic [ADDR_W-1:0] a_q;
    logic              we_q;
    logic [DATA_W-1:0] wd_q;
    logic              err_q;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] if_rd_q;
    logic [DATA_W-1:0] d_rd_q;

    logic              pick_gnt;
    logic              pick_vld;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic              sel_err;
    logic              last_beat;
    logic              in_acc;
    logic              in_resp;

    rr_pick2 u_pick (
        .req   ({d_req, if_req}),
        .last  (last_grant),
        .grant (pick_gnt),
        .valid (pick_vld)
    );

    always_comb begin
        sel_addr  = (pick_gnt == GNT_D) ? d_addr : if_addr;
        sel_we    = (pick_gnt == GNT_D) & d_we;
        sel_err   = sel_addr > MAX_A;
        last_beat = (cnt == '0);
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE: begin
                if (pick_vld)
                    state_n = sel_err ? ST_RESP : ST_ACCESS;
            end
            ST_ACCESS: begin
                if (last_beat)
                    state_n = ST_RESP;
            end
            ST_RESP: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            last_grant <= GNT_D;
            gnt        <= GNT_IF;
            a_q        <= '0;
            we_q       <= 1'b0;
            wd_q       <= '0;
            err_q      <= 1'b0;
            cnt        <= '0;
            if_rd_q    <= '0;
            d_rd_q     <= '0;
        end else begin
            state <= state_n;
            unique case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        gnt        <= pick_gnt;
                        last_grant <= pick_gnt;
                        a_q        <= sel_addr;
                        we_q       <= sel_we;
                        wd_q       <= (pick_gnt == GNT_D) ? d_wdata : '0;
                        err_q      <= sel_err;
                        cnt        <= CNT_INIT;
                        // Out-of-range loads return zero data.
                        if (sel_err && !sel_we) begin
                            if (pick_gnt == GNT_D)
                                d_rd_q <= '0;
                            else
                                if_rd_q <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!last_beat) begin
                        cnt <= cnt - 1'b1;
                    end else if (!we_q) begin
                        if (gnt == GNT_D)
                            d_rd_q <= mem_memData;
                        else
                            if_rd_q <= mem_memData;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_acc        = (state == ST_ACCESS);
        in_resp       = (state == ST_RESP);
        mem_address   = in_acc ? a_q : '0;
        mem_writeData = in_acc ? wd_q : '0;
        mem_memRead   = in_acc & ~we_q;
        // Single write strobe, on the last access beat only.
        mem_memWrite  = in_acc & we_q & last_beat;
        if_ack        = in_resp & (gnt == GNT_IF);
        d_ack         = in_resp & (gnt == GNT_D);
        if_err        = if_ack & err_q;
        d_err         = d_ack & err_q;
        if_rdata      = if_rd_q;
        d_rdata       = d_rd_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a byte-array memory.
// Directed vectors; expected responses queued, checked by a monitor.
module tb_mem_port_arbiter;

    localparam int W = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack, if_err;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ack, d_err;
    logic [31:0] d_rdata;
    logic [31:0] mem_address, mem_writeData;
    logic        mem_memRead, mem_memWrite;
    logic [31:0] mem_memData;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_BYTES(256), .WAIT_CYCLES(W)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .if_err(if_err), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_err(d_err),
        .d_rdata(d_rdata),
        .mem_address(mem_address), .mem_writeData(mem_writeData),
        .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite),
        .mem_memData(mem_memData)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          port;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nerr = 0;
    int   cyc = 0;
    int   rd_cnt = 0;
    int   wr_cnt = 0;
    bit   tput_on = 0;
    bit   tput_first = 0;
    int   last_ack = 0;

    logic [7:0] mem [0:255];

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    function automatic logic [31:0] exp_word(input int a);
        if (a == 0)
            return 32'h00400293;
        return {pat(a + 3), pat(a + 2), pat(a + 1), pat(a)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            mem[i] = pat(i);
        mem[0] = 8'h93; mem[1] = 8'h02; mem[2] = 8'h40; mem[3] = 8'h00;
        forever begin
            @(posedge clk);
            if (mem_memWrite === 1'b1 && mem_address < 32'd253) begin
                mem[mem_address[7:0]]        = mem_writeData[7:0];
                mem[mem_address[7:0] + 8'd1] = mem_writeData[15:8];
                mem[mem_address[7:0] + 8'd2] = mem_writeData[23:16];
                mem[mem_address[7:0] + 8'd3] = mem_writeData[31:24];
            end
        end
    end

    always_comb begin
        mem_memData = '0;
        if (mem_address < 32'd253)
            mem_memData = {mem[mem_address[7:0] + 8'd3],
                           mem[mem_address[7:0] + 8'd2],
                           mem[mem_address[7:0] + 8'd1],
                           mem[mem_address[7:0]]};
    end

    // Monitor: protocol invariants and scoreboard pops.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (mem_memRead === 1'b1) rd_cnt++;
            if (mem_memWrite === 1'b1) wr_cnt++;
            if (mem_memRead === 1'b1 && mem_memWrite === 1'b1) begin
                nerr++;
                $display("FAIL both_strobes: got 1 1 want not both");
            end
            if (if_ack === 1'b1 && d_ack === 1'b1) begin
                nerr++;
                $display("FAIL both_acks: got 1 1 want not both");
            end else if (if_ack === 1'b1 || d_ack === 1'b1) begin
                if (q.size() == 0) begin
                    nerr++;
                    $display("FAIL unexpected_ack: got if=%b d=%b want none",
                             if_ack, d_ack);
                end else begin
                    e = q.pop_front();
                    chk("ack_port", {31'd0, d_ack}, {31'd0, e.port});
                    if (e.port) begin
                        chk("d_err", {31'd0, d_err}, {31'd0, e.err});
                        chk("d_rdata", d_rdata, e.rdata);
                    end else begin
                        chk("if_err", {31'd0, if_err}, {31'd0, e.err});
                        chk("if_rdata", if_rdata, e.rdata);
                    end
                end
                if (tput_on) begin
                    if (!tput_first)
                        chk("ack_period", 32'(cyc - last_ack), 32'(W + 3));
                    tput_first = 0;
                    last_ack = cyc;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input bit p, input bit er,
                                input logic [31:0] rd);
        exp_t e;
        e.port = p; e.err = er; e.rdata = rd;
        return e;
    endfunction

    // Single request on one port; checks ack latency.
    task automatic single(input bit p, input bit we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input bit er);
        int n;
        bit got;
        q.push_back(mk(p, er, rd));
        @(negedge clk);
        if (p) begin
            d_req = 1; d_we = we; d_addr = a; d_wdata = wd;
        end else begin
            if_req = 1; if_addr = a;
        end
        n = 0;
        got = 0;
        while (n < 50 && !got) begin
            @(negedge clk);
            n++;
            got = p ? (d_ack === 1'b1) : (if_ack === 1'b1);
        end
        if (!got) begin
            nerr++;
            $display("FAIL ack_timeout: got none want ack");
        end
        chk("latency", 32'(n), er ? 32'd1 : 32'(W + 2));
        if_req = 0;
        d_req = 0;
        d_we = 0;
    endtask

    // Holds req high across k accesses on one port.
    task automatic burst(input bit p, input int k, input int base);
        int acks = 0;
        int n = 0;
        if (p) begin d_req = 1; d_we = 0; d_addr = base; end
        else begin if_req = 1; if_addr = base; end
        while (acks < k && n < 300) begin
            @(negedge clk);
            n++;
            if ((p && d_ack === 1'b1) || (!p && if_ack === 1'b1)) begin
                acks++;
                if (p) d_addr = base + 4 * acks;
                else if_addr = base + 4 * acks;
            end
        end
        if (acks < k) begin
            nerr++;
            $display("FAIL burst_timeout: got %0d want %0d", acks, k);
        end
        if (p) d_req = 0; else if_req = 0;
    endtask

    logic [31:0] d_model;
    logic [31:0] snap;
    int          w0;
    int          r0;

    initial begin
        // 1: reset with both requests high, then IF wins the first tie.
        if_req = 1; d_req = 1; if_addr = 0; d_addr = 4;
        repeat (3) begin
            @(negedge clk);
            chk("rst_strobes", {30'd0, mem_memRead, mem_memWrite}, 32'd0);
            chk("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
        end
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        q.push_back(mk(0, 0, exp_word(0)));
        q.push_back(mk(1, 0, exp_word(4)));
        reset = 1;
        fork
            burst(0, 1, 0);
            burst(1, 1, 4);
        join
        d_model = exp_word(4);

        // 2: IF read of address 0.
        r0 = rd_cnt;
        single(0, 0, 0, 0, 32'h00400293, 0);
        chk("read_beats", 32'(rd_cnt - r0), 32'(W + 1));

        // 3: store then load at 140.
        w0 = wr_cnt;
        single(1, 1, 140, 32'h00000052, d_model, 0);
        chk("write_beats", 32'(wr_cnt - w0), 32'd1);
        chk("mem140", {mem[143], mem[142], mem[141], mem[140]}, 32'h52);
        single(1, 0, 140, 0, 32'h00000052, 0);
        d_model = 32'h52;

        // 4: both ports saturated; alternating grants.
        for (int i = 0; i < 4; i++) begin
            q.push_back(mk(0, 0, exp_word(32 + 4 * i)));
            q.push_back(mk(1, 0, exp_word(64 + 4 * i)));
        end
        @(negedge clk);
        tput_first = 1;
        tput_on = 1;
        fork
            burst(0, 4, 32);
            burst(1, 4, 64);
        join
        tput_on = 0;
        d_model = exp_word(76);
        chk("q_drained", 32'(q.size()), 32'd0);

        // 6: reset during the first access beat of a store.
        @(negedge clk);
        w0 = wr_cnt;
        d_req = 1; d_we = 1; d_addr = 140; d_wdata = 32'hDEADBEEF;
        @(negedge clk);
        reset = 0; d_req = 0; d_we = 0;
        @(negedge clk);
        reset = 1;
        repeat (4) @(negedge clk);
        chk("abort_writes", 32'(wr_cnt - w0), 32'd0);
        chk("abort_mem", {mem[143], mem[142], mem[141], mem[140]}, 32'h52);
        chk("abort_d_rdata", d_rdata, 32'd0);
        d_model = 32'd0;

        // 5: out-of-range store at 254.
        snap = {mem[255], mem[254], mem[253], mem[252]};
        w0 = wr_cnt;
        single(1, 1, 254, 32'h12345678, d_model, 1);
        chk("err_writes", 32'(wr_cnt - w0), 32'd0);
        chk("err_mem", {mem[255], mem[254], mem[253], mem[252]}, snap);
        chk("err_d_rdata", d_rdata, 32'd0);

        // Boundary: highest legal word and an out-of-range IF fetch.
        single(0, 0, 252, 0, exp_word(252), 0);
        single(0, 0, 253, 0, 32'd0, 1);
        single(1, 0, 140, 0, 32'h52, 0);

        repeat (3) @(negedge clk);
        chk("q_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
